// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//
// Iterative restoring divider with val/rdy stream handshakes on both sides.
// It is the inverse partner of the iterative multiplier and drops into the
// same datapath harness. It computes one quotient bit per clock.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low (0 = reset)
//   istream_val  input message valid
//   istream_rdy  divider can accept an input message (IDLE only)
//   istream_msg  [2*WIDTH-1:WIDTH] dividend, [WIDTH-1:0] divisor
//   ostream_val  result valid (DONE only)
//   ostream_rdy  downstream accepts the result
//   ostream_msg  [2*WIDTH-1:WIDTH] quotient, [WIDTH-1:0] remainder
//
// Parameters
//   WIDTH        operand / quotient / remainder width
//   CNT_W        iteration counter width, 2**CNT_W >= WIDTH
//
// Optional feature
//   SIGNED_DIV_EN  when defined, the operands are two's complement. Magnitudes
//                  are divided, and an extra SIGN state fixes up the signs
//                  (quotient truncates toward zero, and the remainder takes
//                  the dividend's sign). Latency grows to WIDTH+1 edges.
//                  When undefined, the divider is purely unsigned.
// -----------------------------------------------------------------------------
module iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*WIDTH-1:0]   istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [2*WIDTH-1:0]   ostream_msg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
`ifdef SIGNED_DIV_EN
    ,
    SIGN = 2'd3
`endif
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // State and datapath registers
  state_t             r_state;
  logic [WIDTH-1:0]   r_q;      // dividend shifts out, quotient shifts in
  logic [WIDTH:0]     r_r;      // partial remainder, one guard bit
  logic [WIDTH-1:0]   r_d;      // divisor (magnitude in the signed build)
  logic [CNT_W-1:0]   r_cnt;

  // Next-state values from the combinational process
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [WIDTH:0]     w_r_nxt;
  logic [WIDTH-1:0]   w_d_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Operand fields of the incoming message
  logic [WIDTH-1:0]   w_dividend;
  logic [WIDTH-1:0]   w_divisor;

  // One restoring step: shift {R,Q} left by one and trial-subtract D.
  // The extra top bit of w_diff is the borrow, so it is set when T < 0.
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_borrow;

`ifdef SIGNED_DIV_EN
  logic               r_neg_q;  // quotient must be negated in SIGN
  logic               r_neg_r;  // remainder must be negated in SIGN
  logic               w_neg_q_nxt;
  logic               w_neg_r_nxt;

  // Two's complement negation of a WIDTH-bit value
  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a two's complement value (MIN maps to its unsigned magnitude)
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] res;
    if (x[WIDTH-1]) begin
      res = neg_val(x);
    end else begin
      res = x;
    end
    return res;
  endfunction
`endif

  assign w_dividend = istream_msg[2*WIDTH-1:WIDTH];
  assign w_divisor  = istream_msg[WIDTH-1:0];

  assign w_shift  = {r_r, r_q[WIDTH-1]};
  assign w_diff   = w_shift - {2'b00, r_d};
  assign w_borrow = w_diff[WIDTH+1];

  // Gating with rst keeps rdy low while reset is held. The state alone is
  // already IDLE during reset.
  assign istream_rdy = (r_state == IDLE) & rst;
  assign ostream_val = (r_state == DONE);
  assign ostream_msg = {r_q, r_r[WIDTH-1:0]};

  // Next-state and datapath-update logic
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
`ifdef SIGNED_DIV_EN
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
`endif
    case (r_state)
      IDLE: begin
        if (istream_val) begin
`ifdef SIGNED_DIV_EN
          w_q_nxt     = abs_val(w_dividend);
          w_d_nxt     = abs_val(w_divisor);
          // A zero divisor keeps the all-ones quotient un-negated.
          w_neg_q_nxt = (w_dividend[WIDTH-1] ^ w_divisor[WIDTH-1]) &
                        (w_divisor != {WIDTH{1'b0}});
          w_neg_r_nxt = w_dividend[WIDTH-1];
`else
          w_q_nxt     = w_dividend;
          w_d_nxt     = w_divisor;
`endif
          w_r_nxt     = {(WIDTH+1){1'b0}};
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};
        if (w_borrow) begin
          w_r_nxt = w_shift[WIDTH:0];
        end else begin
          w_r_nxt = w_diff[WIDTH:0];
        end
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == LAST_CNT) begin
`ifdef SIGNED_DIV_EN
          w_state_nxt = SIGN;
`else
          w_state_nxt = DONE;
`endif
        end else begin
          w_state_nxt = CALC;
        end
      end
`ifdef SIGNED_DIV_EN
      SIGN: begin
        if (r_neg_q) begin
          w_q_nxt = neg_val(r_q);
        end else begin
          w_q_nxt = r_q;
        end
        if (r_neg_r) begin
          w_r_nxt = {1'b0, neg_val(r_r[WIDTH-1:0])};
        end else begin
          w_r_nxt = r_r;
        end
        w_state_nxt = DONE;
      end
`endif
      DONE: begin
        if (ostream_rdy) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and datapath registers; async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_q     <= {WIDTH{1'b0}};
      r_r     <= {(WIDTH+1){1'b0}};
      r_d     <= {WIDTH{1'b0}};
      r_cnt   <= CNT_ZERO;
`ifdef SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef SIGNED_DIV_EN
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
//
// Self-checking bench for iterative_divider at WIDTH=32. Each send pushes the
// expected {quotient, remainder} onto a scoreboard. A negedge monitor pops the
// scoreboard on every output transfer and also checks latency, output hold
// while stalled, the val drop after a transfer, and that there is no input
// bypass while a result is pending.
// -----------------------------------------------------------------------------
module tb_iterative_divider;

  localparam int W = 32;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic            clk;
  logic            rst;
  logic            istream_val;
  logic            istream_rdy;
  logic [2*W-1:0]  istream_msg;
  logic            ostream_val;
  logic            ostream_rdy;
  logic [2*W-1:0]  ostream_msg;

  logic [2*W-1:0]  sb[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              acc_cyc = 0;
  int              last_xfer_cyc = 0;
  int              last_gap = 0;
  logic            prev_val = 1'b0;
  logic            prev_hold = 1'b0;
  logic            xfer_d = 1'b0;
  logic [2*W-1:0]  prev_msg = '0;
  logic [W-1:0]    ra;
  logic [W-1:0]    rd;
  int              nv;

  iterative_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference quotient/remainder
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] res;
`ifdef SIGNED_DIV_EN
    if (d == 32'h0) begin
      res = {32'hFFFF_FFFF, a};
    end else if (a == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      res = {32'h8000_0000, 32'h0};
    end else begin
      res = {32'($signed(a) / $signed(d)), 32'($signed(a) % $signed(d))};
    end
`else
    if (d == 32'h0) begin
      res = {32'hFFFF_FFFF, a};
    end else begin
      res = {a / d, a % d};
    end
`endif
    return res;
  endfunction

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      prev_val  = 1'b0;
      prev_hold = 1'b0;
      xfer_d    = 1'b0;
    end else begin
      if (xfer_d) chk("val_drop", 64'(ostream_val), 64'(0));
      if (prev_hold) begin
        chk("hold_msg", ostream_msg, prev_msg);
        chk("hold_val", 64'(ostream_val), 64'(1));
      end
      if (ostream_val) chk("no_bypass", 64'(istream_rdy), 64'(0));
      if (ostream_val && !prev_val) chk("latency", 64'(cyc - acc_cyc - 1), 64'(LAT));
      if (istream_val && istream_rdy) begin
        acc_cyc  = cyc;
        last_gap = cyc - last_xfer_cyc;
      end
      if (ostream_val && ostream_rdy) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(1), 64'(0));
        end else begin
          chk("result", ostream_msg, sb.pop_front());
        end
        last_xfer_cyc = cyc;
      end
      xfer_d    = ostream_val && ostream_rdy;
      prev_hold = ostream_val && !ostream_rdy;
      prev_msg  = ostream_msg;
      prev_val  = ostream_val;
    end
  end

  // Drive one operation; returns at the negedge before the accept edge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [63:0] exp);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    istream_val = 1'b1;
    istream_msg = {a, d};
    sb.push_back(exp);
    do begin
      @(negedge clk);
      n++;
    end while (!istream_rdy && n < 200);
    if (!istream_rdy) chk("send_timeout", 64'(0), 64'(1));
  endtask

  // Drop valid after the accept edge and scramble the now-ignored message
  task automatic idle_in();
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
  endtask

  // Wait until every expected result has been popped
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;

    // Outputs while reset is held
    #12;
    chk("rst_irdy", 64'(istream_rdy), 64'(0));
    chk("rst_oval", 64'(ostream_val), 64'(0));
    chk("rst_omsg", ostream_msg, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_irdy", 64'(istream_rdy), 64'(1));
    ostream_rdy = 1'b1;

    // Basic divide
    send(32'd100, 32'd7, {32'd14, 32'd2});
    idle_in();
    drain();

    // Divide by zero
    send(32'h1234_5678, 32'h0, {32'hFFFF_FFFF, 32'h1234_5678});
    idle_in();
    drain();

    // Dividend < divisor with a stalled consumer
    ostream_rdy = 1'b0;
    send(32'd5, 32'd9, {32'd0, 32'd5});
    idle_in();
    nv = 0;
    while (!ostream_val && nv < 100) begin
      @(negedge clk);
      nv++;
    end
    chk("stall_val_seen", 64'(ostream_val), 64'(1));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    ostream_rdy = 1'b1;
    drain();

    // istream_val held high across two back-to-back operations
`ifdef SIGNED_DIV_EN
    send(32'hFFFF_FFFF, 32'h10, {32'h0, 32'hFFFF_FFFF});
`else
    send(32'hFFFF_FFFF, 32'h10, {32'h0FFF_FFFF, 32'hF});
`endif
    send(32'd81, 32'd9, {32'd9, 32'd0});
    idle_in();
    chk("b2b_gap", 64'(last_gap), 64'(1));
    drain();

    // Reset in the middle of CALC drops the operation
    send(32'd1000, 32'd3, {32'd333, 32'd1});
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_oval", 64'(ostream_val), 64'(0));
    chk("midrst_irdy", 64'(istream_rdy), 64'(0));
    chk("midrst_omsg", ostream_msg, 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_release_irdy", 64'(istream_rdy), 64'(1));
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (ostream_val) nv++;
    end
    chk("no_val_after_rst", 64'(nv), 64'(0));
    send(32'd1000, 32'd3, {32'd333, 32'd1});
    idle_in();
    drain();

    // Random operands, occasionally small divisors
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rd = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      send(ra, rd, model(ra, rd));
      idle_in();
      drain();
    end

`ifdef SIGNED_DIV_EN
    send(32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    idle_in();
    drain();
    send(32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0});
    idle_in();
    drain();
    send(32'hFFFF_FFF7, 32'h0, {32'hFFFF_FFFF, 32'hFFFF_FFF7});
    idle_in();
    drain();
    send(32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1});
    idle_in();
    drain();
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
